// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - geometry, window bounds and model encoding shared by the raster timing block
package video_timing_pkg;

  typedef enum logic {
    MODEL_48  = 1'b0,
    MODEL_128 = 1'b1
  } model_e;

  localparam int CW = 9;

  localparam logic [CW-1:0] H_MAX_48  = 9'd447;
  localparam logic [CW-1:0] V_MAX_48  = 9'd311;
  localparam logic [CW-1:0] H_MAX_128 = 9'd455;
  localparam logic [CW-1:0] V_MAX_128 = 9'd310;

  // INT width is 32 T-states (48K) or 36 T-states (128K); one T-state is two pixels.
  localparam logic [CW-1:0] ILEN_48  = 9'd64;
  localparam logic [CW-1:0] ILEN_128 = 9'd72;

  localparam logic [CW-1:0] HBLANK_START = 9'd320;
  localparam logic [CW-1:0] HBLANK_END   = 9'd415;
  localparam logic [CW-1:0] DISP_W       = 9'd256;
  localparam logic [CW-1:0] DISP_H       = 9'd192;

  localparam int VBLANK_PRE  = 8;
  localparam int VBLANK_POST = 7;

  localparam int INT_LINE_DEF    = 248;
  localparam int HSYNC_START_DEF = 344;
  localparam int HSYNC_LEN_DEF   = 32;
  localparam int VSYNC_START_DEF = 248;
  localparam int VSYNC_LEN_DEF   = 4;

  function automatic logic in_window(input logic [CW-1:0] val,
                                     input logic [CW-1:0] lo,
                                     input logic [CW-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/video_counter.sv
// rtl/video_counter.sv - 9-bit wrap counter advanced on ce when inc is set; exposes its next value
module video_counter
  import video_timing_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          inc,
  input  logic [CW-1:0] max,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next,
  output logic          wrap
);

  assign wrap = inc && (count == max);

  always_comb begin
    count_next = count;
    if (wrap)
      count_next = '0;
    else if (inc)
      count_next = count + 9'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (ce)
      count <= count_next;
  end

endmodule

// File: rtl/video_timing.sv
// rtl/video_timing.sv - Spectrum 48K/128K raster timing: counters, blank, syncs, INT, display window
// Optional contention window output is built only when CONTENTION_EN is defined.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int INT_LINE    = INT_LINE_DEF,
  parameter int HSYNC_START = HSYNC_START_DEF,
  parameter int HSYNC_LEN   = HSYNC_LEN_DEF,
  parameter int VSYNC_START = VSYNC_START_DEF,
  parameter int VSYNC_LEN   = VSYNC_LEN_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          model,
  output logic [CW-1:0] hCount,
  output logic [CW-1:0] vCount,
  output logic          blank,
  output logic          hSync,
  output logic          vSync,
  output logic          irq,
  output logic          disp
`ifdef CONTENTION_EN
  ,
  output logic          contend
`endif
);

  localparam logic [CW-1:0] HS_LO = CW'(HSYNC_START);
  localparam logic [CW-1:0] HS_HI = CW'(HSYNC_START + HSYNC_LEN - 1);
  localparam logic [CW-1:0] VS_LO = CW'(VSYNC_START);
  localparam logic [CW-1:0] VS_HI = CW'(VSYNC_START + VSYNC_LEN - 1);
  localparam logic [CW-1:0] VB_LO = CW'(VSYNC_START - VBLANK_PRE);
  localparam logic [CW-1:0] VB_HI = CW'(VSYNC_START + VSYNC_LEN + VBLANK_POST);
  localparam logic [CW-1:0] INT_V = CW'(INT_LINE);

  model_e        lm;
  model_e        lm_next;
  logic [CW-1:0] h_max;
  logic [CW-1:0] v_max;
  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;
  logic [CW-1:0] ilen;
  logic          h_wrap;
  logic          v_wrap;

  assign h_max = (lm == MODEL_128) ? H_MAX_128 : H_MAX_48;
  assign v_max = (lm == MODEL_128) ? V_MAX_128 : V_MAX_48;

  video_counter u_hcnt (
    .clock      (clock),
    .reset      (reset),
    .ce         (ce),
    .inc        (1'b1),
    .max        (h_max),
    .count      (hCount),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  video_counter u_vcnt (
    .clock      (clock),
    .reset      (reset),
    .ce         (ce),
    .inc        (h_wrap),
    .max        (v_max),
    .count      (vCount),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  // Geometry only changes at the 0,0 boundary so a frame never mixes line lengths.
  assign lm_next = (h_wrap && v_wrap) ? model_e'(model) : lm;
  assign ilen    = (lm_next == MODEL_128) ? ILEN_128 : ILEN_48;

  // Flags are decoded from the next counts so they line up with hCount/vCount.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lm    <= MODEL_48;
      blank <= 1'b0;
      hSync <= 1'b0;
      vSync <= 1'b0;
      irq   <= 1'b0;
      disp  <= 1'b0;
    end else if (ce) begin
      lm    <= lm_next;
      blank <= in_window(h_next, HBLANK_START, HBLANK_END) || in_window(v_next, VB_LO, VB_HI);
      hSync <= in_window(h_next, HS_LO, HS_HI);
      vSync <= in_window(v_next, VS_LO, VS_HI);
      irq   <= (v_next == INT_V) && (h_next < ilen);
      disp  <= (h_next < DISP_W) && (v_next < DISP_H);
    end
  end

`ifdef CONTENTION_EN
  // 12 of every 16 pixels inside the bitmap area: the 6-of-8 T-state pattern.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      contend <= 1'b0;
    else if (ce)
      contend <= (v_next < DISP_H) && (h_next < DISP_W) && (h_next[3:0] < 4'd12);
  end
`endif

endmodule

// File: tb/tb_video_timing.sv
// tb/tb_video_timing.sv - directed self-checking bench for video_timing (CONTENTION_EN aware)
module tb_video_timing;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ce    = 1'b0;
  logic       model = 1'b1;
  logic [8:0] hCount;
  logic [8:0] vCount;
  logic       blank;
  logic       hSync;
  logic       vSync;
  logic       irq;
  logic       disp;
`ifdef CONTENTION_EN
  logic       contend;
`endif

  int checks = 0;
  int errors = 0;

  int eh  = 0;
  int ev  = 0;
  int elm = 0;
  int mm  = 0;
  int wraps, irq_cnt, irq_rises, max_h, max_v;
  logic irq_prev;

  always #5 clock = ~clock;

  video_timing dut (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .model   (model),
    .hCount  (hCount),
    .vCount  (vCount),
    .blank   (blank),
    .hSync   (hSync),
    .vSync   (vSync),
    .irq     (irq),
    .disp    (disp)
`ifdef CONTENTION_EN
    ,
    .contend (contend)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    wraps = 0; irq_cnt = 0; irq_rises = 0; max_h = 0; max_v = 0; mm = 0;
    irq_prev = irq;
  endtask

  // One ce pulse; the reference raster advances alongside and every output is compared.
  task automatic pulse();
    logic eb, ehs, evs, eirq, edisp;
    ce = 1'b1;
    @(negedge clock);
    ce = 1'b0;
    if (eh == (elm != 0 ? 455 : 447)) begin
      eh = 0;
      if (ev == (elm != 0 ? 310 : 311)) begin
        ev  = 0;
        elm = int'(model);
      end else begin
        ev++;
      end
    end else begin
      eh++;
    end
    eb    = (eh >= 320 && eh <= 415) || (ev >= 240 && ev <= 259);
    ehs   = (eh >= 344 && eh <= 375);
    evs   = (ev >= 248 && ev <= 251);
    eirq  = (ev == 248) && (eh < (elm != 0 ? 72 : 64));
    edisp = (eh < 256) && (ev < 192);
    if (hCount !== eh[8:0] || vCount !== ev[8:0] || blank !== eb || hSync !== ehs ||
        vSync !== evs || irq !== eirq || disp !== edisp)
      mm++;
`ifdef CONTENTION_EN
    if (contend !== ((ev < 192) && (eh < 256) && ((eh % 16) < 12)))
      mm++;
`endif
    if (hCount == 9'd0 && vCount == 9'd0) wraps++;
    if (irq === 1'b1) irq_cnt++;
    if (irq === 1'b1 && irq_prev !== 1'b1) irq_rises++;
    irq_prev = irq;
    if (int'(hCount) > max_h) max_h = int'(hCount);
    if (int'(vCount) > max_v) max_v = int'(vCount);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_h", hCount, 0);
    check("rst_v", vCount, 0);
    check("rst_blank", blank, 0);
    check("rst_hsync", hSync, 0);
    check("rst_vsync", vSync, 0);
    check("rst_irq", irq, 0);
    check("rst_disp", disp, 0);

    // Frame 1: model=1 from reset, geometry must still be 48K.
    reset = 1'b1;
    @(negedge clock);
    clear_stats();
`ifdef CONTENTION_EN
    run(11);
    check("cont_h11", contend, 1);
    run(1);
    check("cont_h12", contend, 0);
    run(4);
    check("cont_h16", contend, 1);
    run(240);
    check("cont_h256", contend, 0);
    run(448 * 312 - 256);
`else
    run(448 * 312);
`endif
    check("f1_h_end", hCount, 0);
    check("f1_v_end", vCount, 0);
    check("f1_wraps", wraps, 1);
    check("f1_irq_w", irq_cnt, 64);
    check("f1_irq_n", irq_rises, 1);
    check("f1_hmax", max_h, 447);
    check("f1_vmax", max_v, 311);
    check("f1_seq", mm, 0);

    // Frame 2: 128K geometry; model flipped mid-frame must not disturb it.
    clear_stats();
    run(456 * 100);
    check("f2_v100", vCount, 100);
    check("f2_h100", hCount, 0);
    model = 1'b0;
    run(456 * 211);
    check("f2_h_end", hCount, 0);
    check("f2_v_end", vCount, 0);
    check("f2_wraps", wraps, 1);
    check("f2_irq_w", irq_cnt, 72);
    check("f2_irq_n", irq_rises, 1);
    check("f2_hmax", max_h, 455);
    check("f2_vmax", max_v, 310);
    check("f2_seq", mm, 0);

    // Frame 3: back to 448-pixel lines.
    clear_stats();
    run(447);
    check("f3_h447", hCount, 447);
    run(1);
    check("f3_h_wrap", hCount, 0);
    check("f3_v1", vCount, 1);

    // Freeze mid-line inside hblank/hsync, then resume with sparse ce.
    run(350);
    ce = 1'b0;
    repeat (1000) @(negedge clock);
    check("hold_h", hCount, 350);
    check("hold_v", vCount, 1);
    check("hold_blank", blank, 1);
    check("hold_hsync", hSync, 1);
    check("hold_disp", disp, 0);
    for (int i = 0; i < 20; i++) begin
      pulse();
      repeat (7) @(negedge clock);
    end
    check("slow_h", hCount, 370);
    check("slow_seq", mm, 0);

    // Async reset at 300,250.
    model = 1'b1;
    run(78 + 248 * 448 + 300);
    check("pre_rst_h", hCount, 300);
    check("pre_rst_v", vCount, 250);
    check("pre_rst_vsync", vSync, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_h", hCount, 0);
    check("arst_v", vCount, 0);
    check("arst_blank", blank, 0);
    check("arst_vsync", vSync, 0);
    @(negedge clock);
    reset = 1'b1;
    eh = 0; ev = 0; elm = 0;
    clear_stats();
    run(448);
    check("post_rst_h", hCount, 0);
    check("post_rst_v", vCount, 1);
    check("post_rst_seq", mm, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
